// File: rtl/intersection_phase_scheduler.sv
// Two-road intersection phase scheduler (NS main, EW side, pedestrian crossing).
// Tick-timed green/yellow/all-red sequencing with demand-driven green cut/extend and latched walk requests.
module intersection_phase_scheduler #(
    parameter int unsigned CNT_W     = 8,
    parameter int unsigned GREEN_MIN = 10,
    parameter int unsigned GREEN_MAX = 30,
    parameter int unsigned YELLOW_T  = 3,
    parameter int unsigned ALLRED_T  = 2,
    parameter int unsigned PED_T     = 8
) (
    input  logic       clk,
    input  logic       reset_n,
    input  logic       tick,
    input  logic       ew_car,
    input  logic       ped_req,
    output logic       ped_ack,
    output logic       ns_r,
    output logic       ns_y,
    output logic       ns_g,
    output logic       ew_r,
    output logic       ew_y,
    output logic       ew_g,
    output logic       walk,
    output logic [2:0] phase
);

    typedef enum logic [2:0] {
        NS_G  = 3'd0,
        NS_Y  = 3'd1,
        CLR_A = 3'd2,
        EW_G  = 3'd3,
        EW_Y  = 3'd4,
        CLR_B = 3'd5,
        PED   = 3'd6,
        CLR_P = 3'd7
    } state_t;

    typedef enum logic {
        DIR_NS = 1'b0,
        DIR_EW = 1'b1
    } dir_t;

    localparam logic [CNT_W-1:0] GMIN_LAST = CNT_W'(GREEN_MIN - 1);
    localparam logic [CNT_W-1:0] GMAX_LAST = CNT_W'(GREEN_MAX - 1);
    localparam logic [CNT_W-1:0] YEL_LAST  = CNT_W'(YELLOW_T - 1);
    localparam logic [CNT_W-1:0] CLR_LAST  = CNT_W'(ALLRED_T - 1);
    localparam logic [CNT_W-1:0] PED_LAST  = CNT_W'(PED_T - 1);

    state_t           state_q, state_d;
    dir_t             dir_q, dir_d;
    logic [CNT_W-1:0] timer_q, timer_d;
    logic             ped_pend_q, ped_pend_d;
    logic             ped_ack_q, ped_ack_d;

    always_comb begin
        state_d    = state_q;
        dir_d      = dir_q;
        ped_pend_d = ped_pend_q;
        ped_ack_d  = 1'b0;

        if (tick) begin
            unique case (state_q)
                NS_G:  if (timer_q >= GMIN_LAST && (ew_car || ped_pend_q)) state_d = NS_Y;
                NS_Y:  if (timer_q == YEL_LAST) state_d = CLR_A;
                CLR_A: if (timer_q == CLR_LAST) begin
                           state_d = ped_pend_q ? PED : EW_G;
                           dir_d   = DIR_EW;
                       end
                EW_G:  if (timer_q == GMAX_LAST ||
                           (timer_q >= GMIN_LAST && (!ew_car || ped_pend_q))) state_d = EW_Y;
                EW_Y:  if (timer_q == YEL_LAST) state_d = CLR_B;
                CLR_B: if (timer_q == CLR_LAST) begin
                           state_d = ped_pend_q ? PED : NS_G;
                           dir_d   = DIR_NS;
                       end
                PED:   if (timer_q == PED_LAST) state_d = CLR_P;
                CLR_P: if (timer_q == CLR_LAST) state_d = (dir_q == DIR_NS) ? NS_G : EW_G;
                default: state_d = CLR_B;
            endcase
        end

        // A request coinciding with PED entry is consumed by that entry, not re-latched.
        if (state_d == PED && state_q != PED) begin
            ped_pend_d = 1'b0;
            ped_ack_d  = 1'b1;
        end else if (ped_req && state_q != PED) begin
            ped_pend_d = 1'b1;
        end

        if (state_d != state_q)
            timer_d = '0;
        else if (tick && timer_q != '1)
            timer_d = timer_q + 1'b1;
        else
            timer_d = timer_q;
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q    <= CLR_B;
            dir_q      <= DIR_NS;
            timer_q    <= '0;
            ped_pend_q <= 1'b0;
            ped_ack_q  <= 1'b0;
        end else begin
            state_q    <= state_d;
            dir_q      <= dir_d;
            timer_q    <= timer_d;
            ped_pend_q <= ped_pend_d;
            ped_ack_q  <= ped_ack_d;
        end
    end

    // Lamps decode straight from the state register so reset reaches them asynchronously.
    always_comb begin
        ns_r = 1'b0;
        ns_y = 1'b0;
        ns_g = 1'b0;
        ew_r = 1'b0;
        ew_y = 1'b0;
        ew_g = 1'b0;
        walk = 1'b0;
        unique case (state_q)
            NS_G:    begin ns_g = 1'b1; ew_r = 1'b1; end
            NS_Y:    begin ns_y = 1'b1; ew_r = 1'b1; end
            EW_G:    begin ns_r = 1'b1; ew_g = 1'b1; end
            EW_Y:    begin ns_r = 1'b1; ew_y = 1'b1; end
            PED:     begin ns_r = 1'b1; ew_r = 1'b1; walk = 1'b1; end
            default: begin ns_r = 1'b1; ew_r = 1'b1; end
        endcase
    end

    assign ped_ack = ped_ack_q;
    assign phase   = state_q;

endmodule
